// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: CPU SRAM-like ports plus AXI3 master channels; master = bridge view, slave = CPU/AXI-slave view.
interface cpu_axi_bridge_if;
    logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
    logic        data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic [3:0]  arid, arcache, rid, awid, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [7:0]  arlen, awlen;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    modport master (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        output arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awsize, awlen, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready, bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr, inst_sram_wstrb, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
        input  arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
        output arready, rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awsize, awlen, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready, bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: arbitrates CPU inst/data SRAM-like requests onto one AXI3 master, one read per ID and one data op in flight.
module cpu_axi_bridge #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input logic clk,
    input logic resetn,
    cpu_axi_bridge_if.master bus
);
    typedef enum logic {R_IDLE, R_ADDR} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    r_state_t    r_state_q, r_state_d;
    w_state_t    w_state_q, w_state_d;
    logic        inst_out_q, inst_out_d, data_out_q, data_out_d, ready_q;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  arid_q, arid_d, wstrb_q, wstrb_d;
    logic [2:0]  arsize_q, arsize_d, awsize_q, awsize_d;
    logic        data_rd_ok, data_wr_ok, inst_ok, ar_hs, aw_hs, w_hs, r_inst, r_data, b_ok;
    logic        unused_ok;

    assign unused_ok = ^{bus.inst_sram_wr, bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rresp, bus.bresp};

    // A data read also waits out any write so a load never overtakes a store.
    assign data_rd_ok = resetn && r_state_q == R_IDLE && bus.data_sram_req && !bus.data_sram_wr
                        && !data_out_q && w_state_q == W_IDLE;
    assign inst_ok    = resetn && r_state_q == R_IDLE && bus.inst_sram_req && !inst_out_q && !data_rd_ok;
    assign data_wr_ok = resetn && w_state_q == W_IDLE && bus.data_sram_req && bus.data_sram_wr && !data_out_q;
    assign ar_hs  = r_state_q == R_ADDR && bus.arready;
    assign aw_hs  = w_state_q == W_SEND && !aw_done_q && bus.awready;
    assign w_hs   = w_state_q == W_SEND && !w_done_q && bus.wready;
    assign r_inst = resetn && ready_q && bus.rvalid && bus.rid == INST_ID && inst_out_q;
    assign r_data = resetn && ready_q && bus.rvalid && bus.rid == DATA_ID && data_out_q;
    assign b_ok   = resetn && ready_q && w_state_q == W_RESP && bus.bvalid && bus.bid == DATA_ID;

    always_comb begin
        r_state_d  = (data_rd_ok || inst_ok) ? R_ADDR : ar_hs ? R_IDLE : r_state_q;
        araddr_d   = data_rd_ok ? bus.data_sram_addr : inst_ok ? bus.inst_sram_addr : araddr_q;
        arid_d     = data_rd_ok ? DATA_ID : inst_ok ? INST_ID : arid_q;
        arsize_d   = data_rd_ok ? {1'b0, bus.data_sram_size} : inst_ok ? {1'b0, bus.inst_sram_size} : arsize_q;
        inst_out_d = inst_ok || (inst_out_q && !(r_inst && bus.rlast));
        data_out_d = data_rd_ok || (data_out_q && !(r_data && bus.rlast));
        aw_done_d  = !data_wr_ok && (aw_done_q || aw_hs);
        w_done_d   = !data_wr_ok && (w_done_q || w_hs);
        awaddr_d   = data_wr_ok ? bus.data_sram_addr : awaddr_q;
        awsize_d   = data_wr_ok ? {1'b0, bus.data_sram_size} : awsize_q;
        wdata_d    = data_wr_ok ? bus.data_sram_wdata : wdata_q;
        wstrb_d    = data_wr_ok ? bus.data_sram_wstrb : wstrb_q;
        w_state_d  = w_state_q;
        if (data_wr_ok)
            w_state_d = W_SEND;
        else if (w_state_q == W_SEND && aw_done_d && w_done_d)
            w_state_d = W_RESP;
        else if (b_ok)
            w_state_d = W_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state_q  <= R_IDLE;
            w_state_q  <= W_IDLE;
            inst_out_q <= 1'b0;
            data_out_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            w_state_q  <= w_state_d;
            inst_out_q <= inst_out_d;
            data_out_q <= data_out_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ready_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        araddr_q <= araddr_d;
        arid_q   <= arid_d;
        arsize_q <= arsize_d;
        awaddr_q <= awaddr_d;
        awsize_q <= awsize_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end

    assign bus.inst_sram_addr_ok = inst_ok;
    assign bus.inst_sram_data_ok = r_inst;
    assign bus.inst_sram_rdata   = bus.rdata;
    assign bus.data_sram_addr_ok = data_rd_ok || data_wr_ok;
    assign bus.data_sram_data_ok = r_data || b_ok;
    assign bus.data_sram_rdata   = bus.rdata;
    assign bus.arid    = arid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arsize  = arsize_q;
    assign bus.arlen   = 8'd0;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 2'd0;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = r_state_q == R_ADDR;
    assign bus.rready  = ready_q;
    assign bus.awid    = DATA_ID;
    assign bus.awaddr  = awaddr_q;
    assign bus.awsize  = awsize_q;
    assign bus.awlen   = 8'd0;
    assign bus.awburst = 2'b01;
    assign bus.awlock  = 2'd0;
    assign bus.awcache = 4'd0;
    assign bus.awprot  = 3'd0;
    assign bus.awvalid = w_state_q == W_SEND && !aw_done_q;
    assign bus.wid     = DATA_ID;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = w_state_q == W_SEND && !w_done_q;
    assign bus.bready  = ready_q;
endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed vectors with hand-computed expectations for cpu_axi_bridge.
module tb_cpu_axi_bridge;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int checks = 0;
    int errors = 0;

    cpu_axi_bridge_if b();
    cpu_axi_bridge dut (.clk(clk), .resetn(resetn), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
        b.rvalid = 1'b1;
        b.rid = id;
        b.rdata = d;
        b.rlast = 1'b1;
    endtask

    initial begin
        b.inst_sram_req = 0; b.inst_sram_wr = 0; b.inst_sram_size = 0; b.inst_sram_addr = 0;
        b.inst_sram_wstrb = 0; b.inst_sram_wdata = 0;
        b.data_sram_req = 0; b.data_sram_wr = 0; b.data_sram_size = 0; b.data_sram_addr = 0;
        b.data_sram_wstrb = 0; b.data_sram_wdata = 0;
        b.arready = 0; b.rid = 0; b.rdata = 0; b.rresp = 0; b.rlast = 0; b.rvalid = 0;
        b.awready = 0; b.wready = 0; b.bid = 0; b.bresp = 0; b.bvalid = 0;
        step(); step();
        chk("rst_arvalid", b.arvalid, 0);
        chk("rst_awvalid", b.awvalid, 0);
        chk("rst_wvalid", b.wvalid, 0);
        chk("rst_rready", b.rready, 0);
        b.inst_sram_req = 1; #1;
        chk("rst_addr_ok", b.inst_sram_addr_ok, 0);
        b.inst_sram_req = 0;
        resetn = 1;
        step();
        chk("rready", b.rready, 1);
        chk("bready", b.bready, 1);
        chk("arburst", b.arburst, 2'b01);

        // single instruction read
        b.arready = 1;
        b.inst_sram_req = 1; b.inst_sram_addr = 32'h1c000000; b.inst_sram_size = 2; #1;
        chk("i1_addr_ok", b.inst_sram_addr_ok, 1);
        chk("i1_d_addr_ok", b.data_sram_addr_ok, 0);
        step();
        b.inst_sram_req = 0; #1;
        chk("i1_arvalid", b.arvalid, 1);
        chk("i1_araddr", b.araddr, 32'h1c000000);
        chk("i1_arsize", b.arsize, 3'b010);
        chk("i1_arid", b.arid, 0);
        step();
        chk("i1_arvalid_drop", b.arvalid, 0);
        r_beat(4'd0, 32'h02800000); #1;
        chk("i1_data_ok", b.inst_sram_data_ok, 1);
        chk("i1_rdata", b.inst_sram_rdata, 32'h02800000);
        chk("i1_d_data_ok", b.data_sram_data_ok, 0);
        step();
        b.rvalid = 0; #1;
        chk("i1_data_ok_off", b.inst_sram_data_ok, 0);

        // inst and data reads together, data wins, out-of-order return
        b.arready = 0;
        b.inst_sram_req = 1; b.inst_sram_addr = 32'h100;
        b.data_sram_req = 1; b.data_sram_wr = 0; b.data_sram_addr = 32'h200; b.data_sram_size = 2; #1;
        chk("p2_d_addr_ok", b.data_sram_addr_ok, 1);
        chk("p2_i_addr_ok", b.inst_sram_addr_ok, 0);
        step();
        b.data_sram_req = 0; #1;
        chk("p2_arid_d", b.arid, 1);
        chk("p2_araddr_d", b.araddr, 32'h200);
        chk("p2_i_wait", b.inst_sram_addr_ok, 0);
        b.arready = 1;
        step();
        chk("p2_i_addr_ok2", b.inst_sram_addr_ok, 1);
        step();
        b.inst_sram_req = 0; #1;
        chk("p2_arid_i", b.arid, 0);
        chk("p2_araddr_i", b.araddr, 32'h100);
        step();
        r_beat(4'd0, 32'haaaa0000); #1;
        chk("p2_i_data_ok", b.inst_sram_data_ok, 1);
        chk("p2_i_rdata", b.inst_sram_rdata, 32'haaaa0000);
        chk("p2_d_quiet", b.data_sram_data_ok, 0);
        step();
        r_beat(4'd1, 32'hbbbb0001); #1;
        chk("p2_d_data_ok", b.data_sram_data_ok, 1);
        chk("p2_d_rdata", b.data_sram_rdata, 32'hbbbb0001);
        chk("p2_i_quiet", b.inst_sram_data_ok, 0);
        step();
        b.rvalid = 0;

        // arready stalled for 5 cycles
        b.arready = 0;
        b.inst_sram_req = 1; b.inst_sram_addr = 32'h300; #1;
        chk("s_addr_ok", b.inst_sram_addr_ok, 1);
        step();
        b.data_sram_req = 1; b.data_sram_wr = 0; b.data_sram_addr = 32'h500;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s_arvalid", b.arvalid, 1);
            chk("s_araddr", b.araddr, 32'h300);
            chk("s_i_no_ok", b.inst_sram_addr_ok, 0);
            chk("s_d_no_ok", b.data_sram_addr_ok, 0);
            step();
        end
        b.inst_sram_req = 0; b.data_sram_req = 0; b.arready = 1;
        step();
        chk("s_arvalid_drop", b.arvalid, 0);
        r_beat(4'd0, 32'h33); #1;
        chk("s_data_ok", b.inst_sram_data_ok, 1);
        step();
        b.rvalid = 0;

        // write with W delayed behind AW, then a read held off until B
        b.awready = 1; b.wready = 0;
        b.data_sram_req = 1; b.data_sram_wr = 1; b.data_sram_addr = 32'h8000;
        b.data_sram_wdata = 32'h12345678; b.data_sram_wstrb = 4'h3; b.data_sram_size = 1; #1;
        chk("w_addr_ok", b.data_sram_addr_ok, 1);
        step();
        b.data_sram_req = 0; #1;
        chk("w_awvalid", b.awvalid, 1);
        chk("w_wvalid", b.wvalid, 1);
        chk("w_awaddr", b.awaddr, 32'h8000);
        chk("w_awsize", b.awsize, 3'b001);
        chk("w_wdata", b.wdata, 32'h12345678);
        chk("w_wstrb", b.wstrb, 4'h3);
        chk("w_awid", b.awid, 1);
        chk("w_wid", b.wid, 1);
        chk("w_wlast", b.wlast, 1);
        step();
        chk("w_aw_drop", b.awvalid, 0);
        chk("w_w_hold1", b.wvalid, 1);
        step();
        chk("w_w_hold2", b.wvalid, 1);
        step();
        chk("w_w_hold3", b.wvalid, 1);
        b.wready = 1;
        step();
        b.wready = 0; #1;
        chk("w_w_drop", b.wvalid, 0);
        chk("w_aw_stay", b.awvalid, 0);
        b.data_sram_req = 1; b.data_sram_wr = 0; b.data_sram_addr = 32'h400; b.data_sram_size = 2; #1;
        chk("w_rd_blocked1", b.data_sram_addr_ok, 0);
        step();
        chk("w_rd_blocked2", b.data_sram_addr_ok, 0);
        chk("w_no_data_ok", b.data_sram_data_ok, 0);
        b.bvalid = 1; b.bid = 1; #1;
        chk("w_data_ok", b.data_sram_data_ok, 1);
        chk("w_rd_blocked3", b.data_sram_addr_ok, 0);
        step();
        b.bvalid = 0; #1;
        chk("w_data_ok_off", b.data_sram_data_ok, 0);
        chk("w_rd_accept", b.data_sram_addr_ok, 1);
        step();
        b.data_sram_req = 0; #1;
        chk("w_rd_arid", b.arid, 1);
        chk("w_rd_araddr", b.araddr, 32'h400);
        step();
        r_beat(4'd1, 32'hcafe0001); #1;
        chk("w_rd_data_ok", b.data_sram_data_ok, 1);
        chk("w_rd_rdata", b.data_sram_rdata, 32'hcafe0001);
        step();
        b.rvalid = 0;

        // reset in the middle of an AR and a write
        b.arready = 0; b.awready = 0; b.wready = 0;
        b.inst_sram_req = 1; b.inst_sram_addr = 32'h600;
        b.data_sram_req = 1; b.data_sram_wr = 1; b.data_sram_addr = 32'h10; #1;
        chk("x_i_addr_ok", b.inst_sram_addr_ok, 1);
        chk("x_d_addr_ok", b.data_sram_addr_ok, 1);
        step();
        b.inst_sram_req = 0; b.data_sram_req = 0; #1;
        chk("x_arvalid", b.arvalid, 1);
        chk("x_awvalid", b.awvalid, 1);
        resetn = 0;
        step();
        chk("x_arvalid_rst", b.arvalid, 0);
        chk("x_awvalid_rst", b.awvalid, 0);
        chk("x_wvalid_rst", b.wvalid, 0);
        resetn = 1;
        step();
        r_beat(4'd0, 32'h66); b.bvalid = 1; b.bid = 1; #1;
        chk("x_no_i_data_ok", b.inst_sram_data_ok, 0);
        chk("x_no_d_data_ok", b.data_sram_data_ok, 0);
        chk("x_arvalid_idle", b.arvalid, 0);
        step();
        b.rvalid = 0; b.bvalid = 0;
        b.inst_sram_req = 1; b.inst_sram_addr = 32'h700; #1;
        chk("x_i_idle_ok", b.inst_sram_addr_ok, 1);
        b.inst_sram_req = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Converts the CPU's two SRAM-like ports (instruction fetch and data load/store) into a single AXI3 master.
- Sits directly downstream of the CPU top and consumes its inst_sram_* and data_sram_* request streams.
- Arbitrates read requests between the two ports, tracks outstanding transactions, and returns addr_ok/data_ok/rdata to each port.

Parameters:
- INST_ID, 4'd0, AXI ID used for instruction reads.
- DATA_ID, 4'd1, AXI ID used for data reads and for all writes.

Ports:
- clk  input  1  clock; all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- inst_sram_req/wr/size/addr/wstrb/wdata  input  1/1/2/32/4/32  instruction request; wr, wstrb and wdata are ignored (always a read).
- inst_sram_addr_ok  output  1  instruction request accepted this cycle.
- inst_sram_data_ok  output  1  instruction read data valid this cycle.
- inst_sram_rdata  output  32  instruction read data.
- data_sram_req/wr/size/addr/wstrb/wdata  input  1/1/2/32/4/32  data request.
- data_sram_addr_ok  output  1  data request accepted this cycle.
- data_sram_data_ok  output  1  data read data valid, or write completed.
- data_sram_rdata  output  32  data read data.
- arid/araddr/arsize  output  4/32/3  AR channel fields.
- arlen/arburst/arlock/arcache/arprot  output  8/2/2/4/3  tied to 0/2'b01/0/0/0.
- arvalid  output  1  AR valid.
- arready  input  1  AR ready.
- rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  R channel; rresp is ignored.
- rready  output  1  R ready.
- awid/awaddr/awsize  output  4/32/3  AW channel fields.
- awlen/awburst/awlock/awcache/awprot  output  8/2/2/4/3  tied to 0/2'b01/0/0/0.
- awvalid  output  1  AW valid.
- awready  input  1  AW ready.
- wid/wdata/wstrb/wlast/wvalid  output  4/32/4/1/1  W channel; wid = DATA_ID, wlast = 1.
- wready  input  1  W ready.
- bid/bresp/bvalid  input  4/2/1  B channel; bresp is ignored.
- bready  output  1  B ready.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - arvalid=awvalid=wvalid=0.
  - Outstanding flags cleared; both FSMs return to IDLE.
  - addr_ok/data_ok are 0 during reset.
  - A reset mid-transaction abandons that transaction; no data_ok is produced for it afterwards.
- rready and bready are held at 1 from the first cycle after reset.
- Read FSM, states R_IDLE and R_ADDR:
  - In R_IDLE, a request is accepted if its port is eligible. Data read wins over instruction read in the same cycle.
  - The accepting port's addr_ok is asserted combinationally in that same cycle. On that edge the request is latched into araddr, arid and arsize={1'b0,size}, and the FSM goes to R_ADDR.
  - R_ADDR holds arvalid=1 with all fields stable until arready, then returns to R_IDLE. arvalid is never dropped before its handshake.
  - Instruction port is eligible when: no instruction read is outstanding.
  - Data read is eligible when: no data read is outstanding, no write is pending, and the write FSM is idle.
- Outstanding tracking:
  - The inst_out and data_out flags set on acceptance (addr_ok).
  - A flag clears on the R handshake carrying its ID with rlast=1.
  - At most 2 reads can be in flight: one per ID. Responses may return out of order across IDs.
- Read return:
  - inst_sram_data_ok = rvalid & (rid==INST_ID); rdata passes through to inst_sram_rdata.
  - Data reads return the same way on data_sram_data_ok / data_sram_rdata.
  - Both rdata outputs are wired straight from rdata.
- Write FSM, states W_IDLE, W_SEND, W_RESP:
  - Data write (data_sram_wr=1) is accepted in W_IDLE when no data read is outstanding and the read FSM is not latching a data read. data_sram_addr_ok=1 in that cycle.
  - On acceptance, latch awaddr, awsize={1'b0,size}, wdata and wstrb; go to W_SEND.
  - W_SEND raises awvalid and wvalid together. Each valid drops independently after its own handshake; either order or the same cycle is allowed. Leave W_SEND to W_RESP once both handshakes are done.
  - W_RESP waits for bvalid with bid==DATA_ID. data_sram_data_ok is asserted in that cycle, then the FSM returns to W_IDLE.
- Ordering:
  - Only one data transaction of either kind is in flight at once, which prevents read-after-write hazards.
  - Instruction reads proceed concurrently with writes.
- Simultaneous events:
  - Data read data_ok and write data_ok cannot coincide, by the exclusion rule above.
  - An instruction R beat and a B response in the same cycle are both delivered.

Test Plan:
- Single inst read to 0x1c000000 with arready=1 and R returned 2 cycles later (rid=0, rdata=0x02800000): inst addr_ok in cycle 0, arvalid in cycle 1, inst data_ok with rdata 0x02800000, araddr=0x1c000000, arsize=3'b010.
- Inst and data reads requested in the same cycle: data addr_ok first (arid=1); inst addr_ok only after the AR handshake completes; R returned out of order (rid=0 first) routes each rdata to the correct port.
- Data write to 0x8000 with wdata=0x12345678, wstrb=0x3, size=1, with wready delayed 3 cycles after awready: awvalid drops after 1 cycle, wvalid stays high until wready; data_ok asserted in the bvalid cycle; awsize=3'b001.
- Data read requested while a write awaits B: data addr_ok held at 0 until the bvalid cycle; the read is accepted in the following cycle.
- arready held at 0 for 5 cycles: arvalid stays 1 and araddr stays stable; no second addr_ok on either port.
- resetn pulled to 0 while R_ADDR is active and a write is in W_SEND: the next cycle shows arvalid=awvalid=wvalid=0, both FSMs in IDLE, and no data_ok produced.
